// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit path.
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;

  // Packet stall budget: ~20 frame times, rounded up to a whole 100k cycles.
  localparam int unsigned FRAME_BITS    = 10;
  localparam int unsigned TIMEOUT_BYTES = 20;
  localparam int unsigned TIMEOUT_ROUND = 100_000;
  localparam int unsigned TIMEOUT_DFLT  =
    ((BAUD_DIV * FRAME_BITS * TIMEOUT_BYTES + TIMEOUT_ROUND - 1) / TIMEOUT_ROUND) * TIMEOUT_ROUND;
  localparam int unsigned TO_W_DFLT     = 22;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RISE = 3'd3,
    ST_WAIT_FALL = 3'd4,
    ST_HOLD      = 3'd5
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or above the pointer, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx_c,
  output logic               o_any_c
);

  always_comb begin
    o_idx_c = '0;
    o_any_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned k;
      k = 32'(i_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_any_c && i_valid[ID_W'(k)]) begin
        o_idx_c = ID_W'(k);
        o_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART TX core among NUM_REQ byte streams,
// with a stall timeout that revokes a grant whose owner goes quiet mid-packet.
module uart_tx_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned DATA_W         = uart_pkg::DATA_W,
  parameter  int unsigned TIMEOUT_CYCLES = uart_pkg::TIMEOUT_DFLT,
  parameter  int unsigned TO_W           = uart_pkg::TO_W_DFLT,
  localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_active,
  output logic                      timeout_pulse
);

  import uart_pkg::*;

  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_grant_active;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_tx_start;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_timeout_pulse;
  logic               r_last_flag;
  logic [TO_W-1:0]    r_to_cnt;

  logic [ID_W-1:0]    w_ptr_nxt;
  logic [ID_W-1:0]    w_grant_id_nxt;
  logic               w_grant_active_nxt;
  logic [NUM_REQ-1:0] w_req_ready_nxt;
  logic               w_tx_start_nxt;
  logic [DATA_W-1:0]  w_tx_data_nxt;
  logic               w_timeout_pulse_nxt;
  logic               w_last_flag_nxt;
  logic [TO_W-1:0]    w_to_cnt_nxt;

  logic [ID_W-1:0]    w_rr_idx;
  logic               w_rr_any;
  logic [ID_W-1:0]    w_ptr_inc;
  logic [DATA_W-1:0]  w_req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Releasing owner drops to lowest priority for the next arbitration.
  assign w_ptr_inc = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_idx_c (w_rr_idx),
    .o_any_c (w_rr_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next values of every registered output.
  always_comb begin
    w_state_nxt         = r_state;
    w_ptr_nxt           = r_ptr;
    w_grant_id_nxt      = r_grant_id;
    w_grant_active_nxt  = r_grant_active;
    w_req_ready_nxt     = '0;
    w_tx_start_nxt      = 1'b0;
    w_tx_data_nxt       = r_tx_data;
    w_timeout_pulse_nxt = 1'b0;
    w_last_flag_nxt     = r_last_flag;
    w_to_cnt_nxt        = r_to_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if ((|req_valid) && !tx_busy) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (w_rr_any) begin
          w_grant_id_nxt     = w_rr_idx;
          w_grant_active_nxt = 1'b1;
          w_state_nxt        = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_valid[r_grant_id]) begin
          w_req_ready_nxt[r_grant_id] = 1'b1;
          w_tx_start_nxt              = 1'b1;
          w_tx_data_nxt               = w_req_bytes[r_grant_id];
          w_last_flag_nxt             = req_last[r_grant_id];
          w_state_nxt                 = ST_WAIT_RISE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_WAIT_RISE: begin
        if (tx_busy) w_state_nxt = ST_WAIT_FALL;
      end
      ST_WAIT_FALL: begin
        if (!tx_busy) begin
          w_to_cnt_nxt = '0;
          if (r_last_flag) begin
            w_ptr_nxt          = w_ptr_inc;
            w_grant_active_nxt = 1'b0;
            w_state_nxt        = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (req_valid[r_grant_id]) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = ST_ISSUE;
        end else if (r_to_cnt == TO_LIMIT) begin
          w_to_cnt_nxt        = '0;
          w_timeout_pulse_nxt = 1'b1;
          w_ptr_nxt           = w_ptr_inc;
          w_grant_active_nxt  = 1'b0;
          w_state_nxt         = ST_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr           <= '0;
      r_grant_id      <= '0;
      r_grant_active  <= 1'b0;
      r_req_ready     <= '0;
      r_tx_start      <= 1'b0;
      r_tx_data       <= '0;
      r_timeout_pulse <= 1'b0;
      r_last_flag     <= 1'b0;
      r_to_cnt        <= '0;
    end else begin
      r_ptr           <= w_ptr_nxt;
      r_grant_id      <= w_grant_id_nxt;
      r_grant_active  <= w_grant_active_nxt;
      r_req_ready     <= w_req_ready_nxt;
      r_tx_start      <= w_tx_start_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_timeout_pulse <= w_timeout_pulse_nxt;
      r_last_flag     <= w_last_flag_nxt;
      r_to_cnt        <= w_to_cnt_nxt;
    end
  end

  assign req_ready     = r_req_ready;
  assign tx_start      = r_tx_start;
  assign tx_data       = r_tx_data;
  assign grant_id      = r_grant_id;
  assign grant_active  = r_grant_active;
  assign timeout_pulse = r_timeout_pulse;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters, e.g. the command responder, telemetry and debug echo.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until its byte flagged last has been sent, or until it stalls past a timeout.
- Sits between the requesters and the UART TX core inside top_level.
- Drives the core's start/data inputs and follows its busy output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- TIMEOUT_CYCLES, 2_100_000, idle cycles allowed inside a packet before the grant is revoked (about 20 byte times at 100 MHz / 9600 baud)
- TO_W, 22, timeout counter width

Ports:
- clk, in, 1, system clock (100 MHz)
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, NUM_REQ, per-requester byte valid
- req_data, in, NUM_REQ*DATA_W, byte for requester i at [i*8 +: 8]
- req_last, in, NUM_REQ, byte is last of packet; qualified by valid
- req_ready, out, NUM_REQ, one-hot pulse; byte i accepted when valid&ready
- tx_start, out, 1, one-cycle start strobe to the UART TX core
- tx_data, out, DATA_W, byte to the TX core; held stable until tx_busy falls
- tx_busy, in, 1, TX core busy (start bit through stop bit)
- grant_id, out, $clog2(NUM_REQ), current or last owner
- grant_active, out, 1, a packet is in progress
- timeout_pulse, out, 1, one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (asynchronous, immediate): req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, timeout_pulse=0, rr pointer=0, state=IDLE, timeout counter=0. Reset mid-byte abandons the packet. The TX core is reset by the same net.
- States: IDLE, ARB, ISSUE, WAIT_RISE, WAIT_FALL, HOLD.
- IDLE: when any req_valid is set and tx_busy=0, go to ARB.
- ARB (1 cycle): pick the first valid index scanning from the rr pointer upward, with wrap-around. Register grant_id and set grant_active=1. If all valids have dropped, return to IDLE.
- ISSUE (1 cycle): if req_valid[grant_id] is set:
  - pulse req_ready[grant_id] and tx_start in the same cycle;
  - load tx_data from req_data[grant_id];
  - latch last_flag from req_last[grant_id];
  - go to WAIT_RISE.
  - If valid is low, go to HOLD.
- WAIT_RISE: wait for tx_busy=1, then go to WAIT_FALL.
- WAIT_FALL: wait for tx_busy=0, then:
  - if last_flag is set: rr pointer = grant_id+1 (mod NUM_REQ), grant_active=0, go to IDLE;
  - otherwise go to HOLD.
- HOLD: the timeout counter increments each cycle.
  - req_valid[grant_id]=1: clear the counter, go to ISSUE.
  - Counter reaches TIMEOUT_CYCLES-1: pulse timeout_pulse, rr pointer = grant_id+1, grant_active=0, go to IDLE.
  - Other requesters' valids are ignored while in HOLD.
- Latency: with tx_busy low, req_valid rising in IDLE at cycle 0 gives grant at cycle 1 and tx_start/req_ready at cycle 2.
- Inter-byte gap within a packet: valid already high gives tx_start 2 cycles after tx_busy falls (HOLD, ISSUE).
- At most one req_ready bit is high in any cycle; tx_start is never asserted while tx_busy=1.
- Valid may drop before handshake with no effect.
- req_last is ignored when valid is low.
- Single-byte packet (last on the first byte) releases the grant after that byte.
- The rr pointer wraps from NUM_REQ-1 to 0.
- Simultaneous last-byte completion and new requests: the released requester has lowest priority in the next ARB.

Decomposition:
- Shared package uart_pkg:
  - state enum;
  - DATA_W;
  - CLK_HZ=100_000_000, BAUD=9600, BAUD_DIV=10416;
  - TIMEOUT default derived from BAUD_DIV.
- One sub-module rr_arbiter: combinational masked priority encoder (valid vector, pointer) -> index, any. All other logic is the top FSM.

Test Plan:
- Use a TX core stub with 10-cycle busy. Requester 0 sends a single byte 0x41 with last=1 → tx_start at cycle 2, tx_data=0x41, req_ready[0] one pulse, grant_active returns to 0 after busy falls.
- Requesters 0, 1 and 2 each assert a single-byte packet (0xAA, 0xCC, 0xF0, last=1) in the same cycle → transmission order 0, 1, 2; then new 0 and 3 requests → order 3, 0.
- Requester 1 sends a 3-byte packet 0x10, 0x11, 0x12 while requester 0 holds valid throughout → all three bytes sent before any 0 byte; grant_id stays 1.
- Requester 2 sends one non-last byte then goes silent; set TIMEOUT_CYCLES=50 → timeout_pulse exactly once about 50 cycles after busy falls; pending requester 3 is granted next.
- Assert reset_n low mid-WAIT_FALL → all outputs 0 immediately; after release a fresh request is served from pointer 0.
- Requester 3 finishes, then requesters 0 and 3 request → 0 wins (pointer wrap check).
